// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF challenge sequencer: sweeps every RO pair, counts edges of both
// oscillators over a fixed window, and records which oscillator was faster.
module ro_puf_sequencer #(
  parameter int NUM_PAIRS  = 8,
  parameter int SETTLE_CYC = 16,
  parameter int WINDOW_CYC = 4096,
  parameter int CNT_W      = 16
) (
  input  logic                         ICE_CLK,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         ro_a,
  input  logic                         ro_b,
  output logic [$clog2(NUM_PAIRS)-1:0] ro_sel,
  output logic                         ro_en,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_PAIRS-1:0]         response,
  output logic [2:0]                   dbg_state,
  output logic [CNT_W-1:0]             dbg_cnt_a,
  output logic [CNT_W-1:0]             dbg_cnt_b
);

  localparam int SEL_W   = $clog2(NUM_PAIRS);
  localparam int CYC_MAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CYC_W-1:0] WINDOW_LAST = CYC_W'(WINDOW_CYC - 1);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_PAIRS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_COMPARE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [CNT_W-1:0]     cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]     cnt_b_q, cnt_b_d;
  logic [NUM_PAIRS-1:0] resp_q, resp_d;

  // Two-stage synchronizer plus a history flop per oscillator for rising-edge detection.
  logic a_s1_q, a_s1_d, a_s2_q, a_s2_d, a_h_q, a_h_d;
  logic b_s1_q, b_s1_d, b_s2_q, b_s2_d, b_h_q, b_h_d;
  logic edge_a, edge_b;

  always_comb begin
    a_s1_d = ro_a;
    a_s2_d = a_s1_q;
    a_h_d  = a_s2_q;
    b_s1_d = ro_b;
    b_s2_d = b_s1_q;
    b_h_d  = b_s2_q;
  end

  assign edge_a = a_s2_q & ~a_h_q;
  assign edge_b = b_s2_q & ~b_h_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cyc_d   = cyc_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    resp_d  = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_SETTLE;
          sel_d   = '0;
          cyc_d   = '0;
          cnt_a_d = '0;
          cnt_b_d = '0;
        end
      end
      ST_SETTLE: begin
        if (cyc_q == SETTLE_LAST) begin
          state_d = ST_MEASURE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_MEASURE: begin
        // Counters saturate rather than wrap so a fast oscillator never looks slow.
        if (edge_a && cnt_a_q != CNT_MAX) cnt_a_d = cnt_a_q + CNT_W'(1);
        if (edge_b && cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + CNT_W'(1);
        if (cyc_q == WINDOW_LAST) begin
          state_d = ST_COMPARE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_COMPARE: begin
        resp_d[sel_q] = (cnt_a_q > cnt_b_q);
        if (sel_q == SEL_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETTLE;
          sel_d   = sel_q + SEL_W'(1);
          cyc_d   = '0;
          cnt_a_d = '0;
          cnt_b_d = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Abort wins over everything, including a compare landing in the same cycle.
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      sel_d   = sel_q;
      cyc_d   = '0;
      resp_d  = resp_q;
    end
  end

  always_ff @(posedge ICE_CLK or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cyc_q   <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      resp_q  <= '0;
      a_s1_q  <= 1'b0;
      a_s2_q  <= 1'b0;
      a_h_q   <= 1'b0;
      b_s1_q  <= 1'b0;
      b_s2_q  <= 1'b0;
      b_h_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      resp_q  <= resp_d;
      a_s1_q  <= a_s1_d;
      a_s2_q  <= a_s2_d;
      a_h_q   <= a_h_d;
      b_s1_q  <= b_s1_d;
      b_s2_q  <= b_s2_d;
      b_h_q   <= b_h_d;
    end
  end

  assign ro_sel    = sel_q;
  assign ro_en     = (state_q == ST_SETTLE) || (state_q == ST_MEASURE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign response  = resp_q;
  assign dbg_state = state_q;
  assign dbg_cnt_a = cnt_a_q;
  assign dbg_cnt_b = cnt_b_q;

endmodule

// File: doc/ro_puf_sequencer.md
RO_PUF_SEQUENCER -- requirements
Module: ro_puf_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_PAIRS, default 8, meaning the number of ring-oscillator pairs to measure (2..16).
REQ-002 The block SHALL have parameter SETTLE_CYC, default 16, meaning ICE_CLK cycles between oscillator enable and the start of counting.
REQ-003 The block SHALL have parameter WINDOW_CYC, default 4096, meaning ICE_CLK cycles per measurement window.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning the edge-counter width in bits.
REQ-005 The block SHALL have port ICE_CLK, input, 1 bit: the single system clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port start, input, 1 bit: begin a full challenge sweep; sampled only in IDLE.
REQ-008 The block SHALL have port abort, input, 1 bit: terminate any sweep in progress.
REQ-009 The block SHALL have port ro_a, input, 1 bit: divided output of oscillator A of the selected pair, asynchronous to ICE_CLK and below ICE_CLK/4.
REQ-010 The block SHALL have port ro_b, input, 1 bit: divided output of oscillator B of the selected pair, with the same constraints as ro_a.
REQ-011 The block SHALL have port ro_sel, output, clog2(NUM_PAIRS) bits: index of the oscillator pair steered onto ro_a/ro_b.
REQ-012 The block SHALL have port ro_en, output, 1 bit: enable for the selected oscillator pair.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-015 The block SHALL have port response, output, NUM_PAIRS bits: the PUF response, with bit i for pair i.

Function
REQ-016 ro_a and ro_b SHALL each pass through a 2-flop synchronizer plus a history flop; an edge is counted when the synchronized value is 1 and the history value is 0.
REQ-017 The FSM SHALL have the states IDLE, SETTLE, MEASURE, COMPARE and DONE.
REQ-018 In IDLE with start=1 and abort=0, the next cycle SHALL enter SETTLE with ro_sel=0 and both edge counters and the cycle counter cleared.
REQ-019 SETTLE SHALL hold ro_en=1 for exactly SETTLE_CYC cycles, discard all edges, and then enter MEASURE.
REQ-020 MEASURE SHALL hold ro_en=1 for exactly WINDOW_CYC cycles while counting edges into cnt_a and cnt_b, and then enter COMPARE.
REQ-021 Each edge counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 COMPARE SHALL last one cycle with ro_en=0 and write response[ro_sel] = (cnt_a > cnt_b); ties SHALL write 0.
REQ-023 From COMPARE, if ro_sel = NUM_PAIRS-1 the FSM SHALL go to DONE; otherwise it SHALL increment ro_sel, clear the counters and return to SETTLE.
REQ-024 DONE SHALL last one cycle with done=1 and then return to IDLE; done SHALL be 0 in all other states.
REQ-025 ro_en SHALL be 1 only in SETTLE and MEASURE.
REQ-026 ro_sel SHALL change only on the entry to SETTLE.
REQ-027 The latency from start sampled to the done pulse SHALL be NUM_PAIRS*(SETTLE_CYC+WINDOW_CYC+1)+1 cycles.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE on the next cycle with ro_en=0, no done pulse, and response retaining its pre-sweep value except for bits already written.
REQ-029 Simultaneous start and abort in IDLE SHALL leave the FSM in IDLE.
REQ-030 start while busy SHALL be ignored.
REQ-031 response SHALL be updated only in COMPARE and SHALL otherwise hold its value across sweeps.

Reset
REQ-032 While rst=1, the block SHALL hold state=IDLE, ro_sel=0, ro_en=0, busy=0, done=0, response=0, all counters=0 and all synchronizer flops=0, asynchronously.
REQ-033 Reset deassertion mid-sweep SHALL resume from IDLE only; no partial sweep continues.

Verification
REQ-034 NUM_PAIRS=4, SETTLE_CYC=4, WINDOW_CYC=64, ro_a period 8 cycles, ro_b period 12 cycles on all pairs, pulse start -> done on cycle 4*(4+64+1)+1=277 after start, response=4'b1111.
REQ-035 Same configuration with ro_a period 12 cycles and ro_b period 8 cycles on pairs 1 and 3 only -> response=4'b0101.
REQ-036 ro_a and ro_b driven by an identical period-8 source -> every bit of response=0 (tie rule); ro_en low for exactly one cycle between pairs.
REQ-037 CNT_W=3, ro_a period 4, ro_b period 6 -> both counters saturate at 7 and response bit=0; check no wrap occurs.
REQ-038 abort asserted at cycle 100 (pair 1, in MEASURE) -> state is IDLE at cycle 101, ro_en=0, no done pulse, response[0] written and response[3:1] unchanged; a second start then completes normally.
REQ-039 rst pulsed mid-MEASURE, plus start held during busy -> all outputs read 0 immediately with rst, and the extra start causes no restart or double done.
